// File: rtl/shift_seq_pkg.sv
// Shared types and default sizes for the shift_seq command sequencer.
// Optional shadow checker is enabled with SHIFT_SEQ_CHECK_EN.
package shift_seq_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefCntW  = 3;

    typedef enum logic [1:0] {
        OpNop  = 2'b00,
        OpLoad = 2'b01,
        OpShr  = 2'b10,
        OpShl  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/shift_seq_shadow.sv
// Shadow copy of the downstream loop shift register; flags any divergence of q
// once the shadow has been loaded. Used only when SHIFT_SEQ_CHECK_EN is defined.
module shift_seq_shadow
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ld,
    input  logic             i_s_cnt,
    input  logic             i_sr,
    input  logic             i_sl,
    input  logic [WIDTH-1:0] i_d_in,
    input  logic [WIDTH-1:0] i_q,
    output logic             o_err
);

    logic [WIDTH-1:0] r_shadow;
    logic             r_valid;
    logic             r_err;

    // Updates on the same edge as the real register, so both stay aligned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (i_ld) begin
                r_shadow <= i_d_in;
                r_valid  <= 1'b1;
            end else if (i_s_cnt && i_sr) begin
                r_shadow <= {r_shadow[0], r_shadow[WIDTH-1:1]};
            end else if (i_s_cnt && i_sl) begin
                r_shadow <= {r_shadow[WIDTH-2:0], r_shadow[WIDTH-1]};
            end
            if (r_valid && (i_q != r_shadow)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/shift_seq.sv
// Command sequencer driving a loop shift register's ld/s_cnt/sr/sl lines.
// Define SHIFT_SEQ_CHECK_EN to add the shadow-register divergence checker.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic [CNT_W-1:0] i_cmd_cnt,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_d_in,
    output logic             o_ld,
    output logic             o_s_cnt,
    output logic             o_sr,
    output logic             o_sl,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    state_e           r_state;
    logic             r_ready;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_d_in;
    logic             r_ld;
    logic             r_s_cnt;
    logic             r_sr;
    logic             r_sl;
    logic             r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_d_in  <= '0;
            r_ld    <= 1'b0;
            r_s_cnt <= 1'b0;
            r_sr    <= 1'b0;
            r_sl    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ld    <= 1'b0;
            r_s_cnt <= 1'b0;
            r_sr    <= 1'b0;
            r_sl    <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Ready rises one cycle after reset release or after DONE.
                    r_ready <= 1'b1;
                    if (i_cmd_valid && r_ready) begin
                        r_ready <= 1'b0;
                        unique case (op_e'(i_cmd_op))
                            OpLoad: begin
                                r_d_in  <= i_cmd_data;
                                r_ld    <= 1'b1;
                                r_state <= StLoad;
                            end
                            OpShr, OpShl: begin
                                if (i_cmd_cnt != '0) begin
                                    r_cnt   <= i_cmd_cnt;
                                    r_s_cnt <= 1'b1;
                                    r_sr    <= (op_e'(i_cmd_op) == OpShr);
                                    r_sl    <= (op_e'(i_cmd_op) == OpShl);
                                    r_state <= StShift;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_state <= StDone;
                                end
                            end
                            OpNop: begin
                                r_done  <= 1'b1;
                                r_state <= StDone;
                            end
                        endcase
                    end
                end
                StLoad: begin
                    r_done  <= 1'b1;
                    r_state <= StDone;
                end
                StShift: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_s_cnt <= 1'b1;
                        r_sr    <= r_sr;
                        r_sl    <= r_sl;
                    end
                end
                StDone: begin
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_d_in      = r_d_in;
    assign o_ld        = r_ld;
    assign o_s_cnt     = r_s_cnt;
    assign o_sr        = r_sr;
    assign o_sl        = r_sl;
    assign o_done      = r_done;
    assign o_busy      = (r_state != StIdle);

`ifdef SHIFT_SEQ_CHECK_EN
    shift_seq_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ld    (r_ld),
        .i_s_cnt (r_s_cnt),
        .i_sr    (r_sr),
        .i_sl    (r_sl),
        .i_d_in  (r_d_in),
        .i_q     (i_q),
        .o_err   (o_err)
    );
`else
    logic w_unused_q;
    assign w_unused_q = ^i_q;
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a scoreboard of expected command outcomes
// and a behavioural loop shift register closing the q feedback path.
module tb_shift_seq;

    localparam int W = 4;
    localparam int C = 3;
`ifdef SHIFT_SEQ_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] LD  = 2'b01;
    localparam logic [1:0] SHR = 2'b10;
    localparam logic [1:0] SHL = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic [C-1:0] cmd_cnt = '0;
    logic [W-1:0] q;
    logic         cmd_ready, ld, s_cnt, sr, sl, busy, done, err;
    logic [W-1:0] d_in;

    logic [W-1:0] sr_q = '0;
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] d;
        int           lat;
        int           step_mask;
        int           ld_mask;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_din = '0;

    always #5 clk = ~clk;

    assign q = force_en ? force_val : sr_q;

    // Behavioural downstream loop shift register.
    always_ff @(posedge clk) begin
        if (ld) sr_q <= d_in;
        else if (s_cnt && sr) sr_q <= {sr_q[0], sr_q[W-1:1]};
        else if (s_cnt && sl) sr_q <= {sr_q[W-2:0], sr_q[W-1]};
    end

    always @(negedge clk) begin
        if ((sr && sl) || (ld && s_cnt)) viol++;
    end

    shift_seq u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_data  (cmd_data),
        .i_cmd_cnt   (cmd_cnt),
        .i_q         (q),
        .o_d_in      (d_in),
        .o_ld        (ld),
        .o_s_cnt     (s_cnt),
        .o_sr        (sr),
        .o_sl        (sl),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rot(input logic [W-1:0] v, input int n, input bit left);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = left ? {r[W-2:0], r[W-1]} : {r[0], r[W-1:1]};
        return r;
    endfunction

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] data,
                           input logic [C-1:0] cnt, input bit hold);
        exp_t e;
        exp_t g;
        int   lat, smask, lmask, wt;
        bit   got_done, rdy_busy, idle_busy, bad_din;
        bit   is_sh;
        is_sh       = (op == SHR || op == SHL) && (cnt != 0);
        e.lat       = (op == LD) ? 2 : (is_sh ? int'(cnt) + 1 : 1);
        e.step_mask = is_sh ? (((1 << cnt) - 1) << 1) : 0;
        e.ld_mask   = (op == LD) ? 2 : 0;
        e.q         = (op == LD) ? data : (is_sh ? rot(m_q, int'(cnt), op == SHL) : m_q);
        e.d         = (op == LD) ? data : m_din;
        m_q = e.q;
        m_din = e.d;
        sb.push_back(e);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        wt = 0;
        while (!cmd_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk({tag, " accept"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        lat = 0; smask = 0; lmask = 0;
        got_done = 0; rdy_busy = 0; idle_busy = 0; bad_din = 0;
        while (!got_done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!hold) cmd_valid = 1'b0;
            if (s_cnt) smask |= (1 << lat);
            if (ld) lmask |= (1 << lat);
            if (ld && d_in !== e.d) bad_din = 1;
            if (cmd_ready) rdy_busy = 1;
            if (!busy) idle_busy = 1;
            if (done) got_done = 1;
        end
        cmd_valid = 1'b0;
        g = sb.pop_front();
        chk({tag, " done latency"}, 32'(lat), 32'(g.lat));
        chk({tag, " step cycles"}, 32'(smask), 32'(g.step_mask));
        chk({tag, " ld cycles"}, 32'(lmask), 32'(g.ld_mask));
        chk({tag, " q"}, 32'(sr_q), 32'(g.q));
        chk({tag, " d_in"}, {31'd0, bad_din} | 32'(d_in), 32'(g.d));
        chk({tag, " ready/busy during cmd"}, {30'd0, rdy_busy, idle_busy}, 32'd0);
        @(negedge clk);
        chk({tag, " ready after"}, {30'd0, cmd_ready, busy}, 32'b10);
    endtask

    initial begin
        logic [W-1:0] q_at_rst;
        int           stray;

        repeat (2) @(negedge clk);
        chk("reset ctrl", {24'd0, cmd_ready, busy, done, ld, s_cnt, sr, sl, err}, 32'd0);
        chk("reset d_in", 32'(d_in), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after release", 32'(cmd_ready), 32'd1);

        run_cmd("load1010", LD, 4'b1010, 3'd0, 1'b0);
        run_cmd("shr1", SHR, 4'b0000, 3'd1, 1'b0);
        run_cmd("shl1", SHL, 4'b0000, 3'd1, 1'b0);
        run_cmd("shr4 held", SHR, 4'b1111, 3'd4, 1'b1);
        run_cmd("nop", NOP, 4'b0110, 3'd5, 1'b0);
        run_cmd("shl0", SHL, 4'b0110, 3'd0, 1'b0);
        run_cmd("shl3", SHL, 4'b0000, 3'd3, 1'b0);
        run_cmd("load0011", LD, 4'b0011, 3'd0, 1'b0);
        run_cmd("shr2", SHR, 4'b0000, 3'd2, 1'b0);
        run_cmd("shl7", SHL, 4'b0000, 3'd7, 1'b0);
        chk("err clean run", 32'(err), 32'd0);

        // Reset in the second step cycle of SHR 7: only one step reaches the register.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = SHR;
        cmd_cnt   = 3'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst ctrl", {24'd0, cmd_ready, busy, done, ld, s_cnt, sr, sl, err}, 32'd0);
        chk("midrst d_in", 32'(d_in), 32'd0);
        q_at_rst = sr_q;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_cnt || ld || busy) stray++;
        end
        chk("midrst no steps", 32'(stray), 32'd0);
        chk("midrst q one step", 32'(sr_q), 32'(rot(m_q, 1, 1'b0)));
        chk("midrst q frozen", 32'(sr_q), 32'(q_at_rst));
        m_q = sr_q;
        m_din = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst ready after release", {30'd0, cmd_ready, busy}, 32'b10);

        run_cmd("load0110", LD, 4'b0110, 3'd0, 1'b0);
        chk("err before force", 32'(err), 32'd0);
        force_en  = 1'b1;
        force_val = 4'b1011;
        run_cmd("load1010 forced q", LD, 4'b1010, 3'd0, 1'b0);
        chk("err on mismatch", 32'(err), 32'(ChkEn));
        force_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("err sticky", 32'(err), 32'(ChkEn));
        rst_n = 1'b0;
        @(negedge clk);
        chk("err cleared by reset", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        chk("sr/sl and ld/s_cnt exclusive", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
